// File: rtl/txdata_framer.sv
// Transceiver TX framer: link training with K28.5 comma words, then user payload
// with periodic comma insertion so the far-end receiver keeps word alignment.
module txdata_framer #(
   parameter int COMMA_PERIOD = 256,
   parameter int TRAIN_MIN    = 1024
) (
   input  logic        txusrclk2,
   input  logic        rst,
   input  logic        tx_ready,
   input  logic        remote_aligned,
   input  logic [31:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   output logic [31:0] txdata,
   output logic [7:0]  txctrl2,
   output logic [15:0] txctrl0,
   output logic [15:0] txctrl1,
   output logic        tx8b10ben,
   output logic        link_up,
   output logic        comma_sent
);

   localparam logic [31:0] COMMA_WORD  = 32'h5050_50BC;
   localparam logic [15:0] PERIOD_LAST = 16'(COMMA_PERIOD - 1);
   localparam logic [15:0] TRAIN_LIMIT = 16'(TRAIN_MIN);

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      TRAIN = 2'd1,
      DATA  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [15:0] train_cnt;
   logic [15:0] train_next;
   logic [15:0] period_cnt;
   logic [15:0] period_next;
   logic        ra_meta;
   logic        ra_sync;
   logic [31:0] word_next;
   logic [7:0]  ctrl_next;
   logic        comma_next;
   logic        link_next;
   logic        accept;

   assign txctrl0   = 16'h0000;
   assign txctrl1   = 16'h0000;
   assign tx8b10ben = 1'b1;

   // Ready is withheld on the forced-comma slot and whenever the datapath drops.
   assign s_tready = (state == DATA) && (period_cnt != PERIOD_LAST) && tx_ready && !rst;
   assign accept   = s_tvalid & s_tready;

   always_comb begin
      state_next  = state;
      train_next  = train_cnt;
      period_next = period_cnt;
      word_next   = COMMA_WORD;
      ctrl_next   = 8'h01;
      comma_next  = 1'b1;
      if (!tx_ready) begin
         state_next  = WAIT;
         train_next  = 16'd0;
         period_next = 16'd0;
      end else begin
         case (state)
            WAIT: begin
               state_next  = TRAIN;
               train_next  = 16'd0;
               period_next = 16'd0;
            end
            TRAIN: begin
               if ((train_cnt >= TRAIN_LIMIT) && ra_sync) begin
                  state_next  = DATA;
                  period_next = 16'd0;
               end else if (train_cnt != 16'hFFFF) begin
                  train_next = train_cnt + 16'd1;
               end else begin
                  train_next = train_cnt;
               end
            end
            DATA: begin
               // An accepted word is always driven, even if alignment is lost now.
               if (accept) begin
                  word_next   = s_tdata;
                  ctrl_next   = 8'h00;
                  comma_next  = 1'b0;
                  period_next = period_cnt + 16'd1;
               end else begin
                  period_next = 16'd0;
               end
               if (!ra_sync) begin
                  state_next  = TRAIN;
                  train_next  = 16'd0;
                  period_next = 16'd0;
               end else begin
                  state_next = DATA;
               end
            end
            default: begin
               state_next  = WAIT;
               train_next  = 16'd0;
               period_next = 16'd0;
            end
         endcase
      end
      link_next = (state_next == DATA);
   end

   always_ff @(posedge txusrclk2) begin
      if (rst) begin
         state      <= WAIT;
         train_cnt  <= 16'd0;
         period_cnt <= 16'd0;
         ra_meta    <= 1'b0;
         ra_sync    <= 1'b0;
         txdata     <= COMMA_WORD;
         txctrl2    <= 8'h01;
         comma_sent <= 1'b0;
         link_up    <= 1'b0;
      end else begin
         state      <= state_next;
         train_cnt  <= train_next;
         period_cnt <= period_next;
         ra_meta    <= remote_aligned;
         ra_sync    <= ra_meta;
         txdata     <= word_next;
         txctrl2    <= ctrl_next;
         comma_sent <= comma_next;
         link_up    <= link_next;
      end
   end

endmodule

// File: tb/tb_txdata_framer.sv
// Randomized bench for txdata_framer against a cycle-level link model.
module tb_txdata_framer;

   localparam int CP = 4;
   localparam int TM = 16;
   localparam logic [31:0] COMMA = 32'h5050_50BC;

   logic        clk = 1'b0;
   logic        rst, tx_ready, remote_aligned, s_tvalid;
   logic [31:0] s_tdata;
   logic        s_tready, tx8b10ben, link_up, comma_sent;
   logic [31:0] txdata;
   logic [7:0]  txctrl2;
   logic [15:0] txctrl0, txctrl1;

   int checks = 0;
   int errors = 0;

   // model: mode 0 = waiting, 1 = training, 2 = carrying data
   int          m_mode, m_train, m_run;
   logic        ra_m, ra_s;
   logic [31:0] e_data;
   logic [7:0]  e_ctrl;
   logic        e_cs, e_link;

   always #5 clk = ~clk;

   txdata_framer #(.COMMA_PERIOD(CP), .TRAIN_MIN(TM)) dut (
      .txusrclk2(clk), .rst(rst), .tx_ready(tx_ready), .remote_aligned(remote_aligned),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .txdata(txdata), .txctrl2(txctrl2), .txctrl0(txctrl0), .txctrl1(txctrl1),
      .tx8b10ben(tx8b10ben), .link_up(link_up), .comma_sent(comma_sent)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_comma();
      e_data = COMMA;
      e_ctrl = 8'h01;
      e_cs   = 1'b1;
   endtask

   // One clock: check ready before the edge, advance model, check registered outputs.
   task automatic cycle();
      logic exp_rdy;
      #1;
      exp_rdy = (m_mode == 2) && (m_run != CP - 1) && tx_ready && !rst;
      chk("s_tready", {31'd0, s_tready}, {31'd0, exp_rdy});
      @(posedge clk);
      if (rst) begin
         m_mode = 0; m_train = 0; m_run = 0;
         model_comma();
         e_cs = 1'b0;
      end else if (!tx_ready) begin
         model_comma();
         m_mode = 0; m_train = 0; m_run = 0;
      end else if (m_mode == 0) begin
         model_comma();
         m_mode = 1; m_train = 0;
      end else if (m_mode == 1) begin
         model_comma();
         if (m_train >= TM && ra_s) begin
            m_mode = 2; m_run = 0;
         end else if (m_train < 65535) begin
            m_train++;
         end
      end else begin
         if (s_tvalid && m_run < CP - 1) begin
            e_data = s_tdata; e_ctrl = 8'h00; e_cs = 1'b0;
            m_run++;
         end else begin
            model_comma();
            m_run = 0;
         end
         if (!ra_s) begin
            m_mode = 1; m_train = 0; m_run = 0;
         end
      end
      e_link = (m_mode == 2);
      ra_s = rst ? 1'b0 : ra_m;
      ra_m = rst ? 1'b0 : remote_aligned;
      #1;
      chk("txdata", txdata, e_data);
      chk("txctrl2", {24'd0, txctrl2}, {24'd0, e_ctrl});
      chk("comma_sent", {31'd0, comma_sent}, {31'd0, e_cs});
      chk("link_up", {31'd0, link_up}, {31'd0, e_link});
      chk("ctrl01_8b10b", {txctrl0, txctrl1[15:1], tx8b10ben}, 32'h0000_0001);
      @(negedge clk);
   endtask

   initial begin
      int ncomma;
      int seen_down;
      logic [31:0] cnt;
      rst = 1'b1; tx_ready = 1'b1; remote_aligned = 1'b1; s_tvalid = 1'b0; s_tdata = 32'd0;
      m_mode = 0; m_train = 0; m_run = 0; ra_m = 1'b0; ra_s = 1'b0;
      model_comma(); e_cs = 1'b0; e_link = 1'b0;
      @(posedge clk);
      @(negedge clk);
      repeat (3) cycle();

      // bring-up: count commas until the link comes up
      rst = 1'b0;
      ncomma = 0;
      for (int i = 0; i < 200 && !link_up; i++) begin
         cycle();
         if (comma_sent) ncomma++;
      end
      chk("bringup_link", {31'd0, link_up}, 32'd1);
      chk("bringup_commas", (ncomma >= TM) ? 32'd1 : 32'd0, 32'd1);

      // continuous stream, incrementing data
      cnt = 32'd100;
      s_tvalid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_tdata = cnt;
         #1;
         if (s_tready) cnt = cnt + 32'd1;
         cycle();
      end

      // idle then resume
      s_tvalid = 1'b0;
      repeat (10) cycle();
      s_tvalid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         s_tdata = $urandom;
         cycle();
      end

      // remote alignment loss: link must drop within 4 cycles
      remote_aligned = 1'b0;
      seen_down = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         if (!link_up) seen_down = 1;
      end
      chk("ra_loss_link", seen_down, 32'd1);
      repeat (6) cycle();
      remote_aligned = 1'b1;
      for (int i = 0; i < 40; i++) begin
         s_tdata = $urandom;
         cycle();
      end
      chk("ra_relink", {31'd0, link_up}, 32'd1);

      // tx_ready drop mid-stream
      tx_ready = 1'b0;
      repeat (5) cycle();
      chk("txrdy_drop_link", {31'd0, link_up}, 32'd0);
      tx_ready = 1'b1;
      repeat (30) cycle();

      // reset mid-DATA with valid held high
      s_tvalid = 1'b1;
      rst = 1'b1;
      cycle();
      chk("rst_txdata", txdata, COMMA);
      rst = 1'b0;
      cycle();

      // randomized soak
      for (int i = 0; i < 3000; i++) begin
         s_tvalid = ($urandom_range(0, 3) != 0);
         s_tdata  = $urandom;
         if ($urandom_range(0, 60) == 0) remote_aligned = ~remote_aligned;
         if ($urandom_range(0, 150) == 0) tx_ready = 1'b0;
         else if ($urandom_range(0, 4) == 0) tx_ready = 1'b1;
         rst = ($urandom_range(0, 500) == 0);
         if (i % 400 == 0) begin
            remote_aligned = 1'b1;
            tx_ready = 1'b1;
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
